// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: single-issue controller for a 32x16 register file.
// Takes one three-operand ALU command, reads rs/rt on the file's two
// read ports, computes, writes the result to rd, then pulses done.
//
// Build option: define RF_SEQ_ZERO_REG_EN to make register 0 read as zero
// and to drop writes aimed at it (timing and done are unaffected).
//
// Sequence (RD_LAT=1), start sampled at edge 0:
//   cycle 1 READ  : valid=110, read addresses = rs/rt
//   cycle 2 WAIT  : valid=000, operands captured at the exit edge
//   cycle 3 WRITE : valid=001, write address/data = rd/result
//   cycle 4 DONE  : done=1
module rf_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] rf_read_address1,
    output logic [ADDR_W-1:0] rf_read_address2,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [2:0]        rf_valid_address,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [ADDR_W-1:0] rf_read_address1_q, rf_read_address1_d;
    logic [ADDR_W-1:0] rf_read_address2_q, rf_read_address2_d;
    logic [ADDR_W-1:0] rf_write_address_q, rf_write_address_d;
    logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
    logic [2:0]        rf_valid_address_q, rf_valid_address_d;

    logic [DATA_W-1:0] opnd_a, opnd_b, alu_out;
    logic              wr_allowed;

    // The read address registers hold rs/rt for the whole command, so they
    // double as the latched source addresses for zero-register detection.
`ifdef RF_SEQ_ZERO_REG_EN
    assign opnd_a     = (rf_read_address1_q == '0) ? '0 : rf_read_data1;
    assign opnd_b     = (rf_read_address2_q == '0) ? '0 : rf_read_data2;
    assign wr_allowed = (rd_q != '0);
`else
    assign opnd_a     = rf_read_data1;
    assign opnd_b     = rf_read_data2;
    assign wr_allowed = 1'b1;
`endif

    // ALU: DATA_W-bit modulo arithmetic, carry/borrow dropped.
    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_ADD:  alu_out = opnd_a + opnd_b;
            OP_SUB:  alu_out = opnd_a - opnd_b;
            OP_AND:  alu_out = opnd_a & opnd_b;
            OP_OR:   alu_out = opnd_a | opnd_b;
            default: alu_out = '0;
        endcase
    end

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so every output comes straight from a flop.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        op_d               = op_q;
        rd_d               = rd_q;
        result_d           = result_q;
        rf_read_address1_d = rf_read_address1_q;
        rf_read_address2_d = rf_read_address2_q;
        rf_write_address_d = rf_write_address_q;
        rf_write_data_d    = rf_write_data_q;
        rf_valid_address_d = 3'b000;
        done_d             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d               = opcode;
                    rd_d               = rd_addr;
                    rf_read_address1_d = rs_addr;
                    rf_read_address2_d = rt_addr;
                    rf_valid_address_d = 3'b110;
                    state_d            = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    result_d           = alu_out;
                    rf_write_address_d = rd_q;
                    rf_write_data_d    = alu_out;
                    rf_valid_address_d = {2'b00, wr_allowed};
                    state_d            = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            op_q               <= '0;
            rd_q               <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            result_q           <= '0;
            rf_read_address1_q <= '0;
            rf_read_address2_q <= '0;
            rf_write_address_q <= '0;
            rf_write_data_q    <= '0;
            rf_valid_address_q <= 3'b000;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            op_q               <= op_d;
            rd_q               <= rd_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            result_q           <= result_d;
            rf_read_address1_q <= rf_read_address1_d;
            rf_read_address2_q <= rf_read_address2_d;
            rf_write_address_q <= rf_write_address_d;
            rf_write_data_q    <= rf_write_data_d;
            rf_valid_address_q <= rf_valid_address_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;
    assign rf_read_address1 = rf_read_address1_q;
    assign rf_read_address2 = rf_read_address2_q;
    assign rf_write_address = rf_write_address_q;
    assign rf_write_data    = rf_write_data_q;
    assign rf_valid_address = rf_valid_address_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Testbench for rf_op_sequencer: a behavioural 32x16 register file sits on
// the rf_* ports, and a reference model (array of register values plus the
// ALU rules) predicts every result, write and per-cycle control pattern.
module tb_rf_op_sequencer;

`ifdef RF_SEQ_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  opcode;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        busy, done;
    logic [15:0] result;
    logic [4:0]  rf_read_address1, rf_read_address2, rf_write_address;
    logic [15:0] rf_write_data;
    logic [2:0]  rf_valid_address;
    logic [15:0] rf_read_data1, rf_read_data2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Register file attached to the sequencer, and the reference contents.
    logic [15:0] mem    [32];
    logic [15:0] ref_rf [32];
    int          wr_count = 0;

    rf_op_sequencer #(.DATA_W(16), .ADDR_W(5), .RD_LAT(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .opcode           (opcode),
        .rs_addr          (rs_addr),
        .rt_addr          (rt_addr),
        .rd_addr          (rd_addr),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .rf_read_address1 (rf_read_address1),
        .rf_read_address2 (rf_read_address2),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_valid_address (rf_valid_address),
        .rf_read_data1    (rf_read_data1),
        .rf_read_data2    (rf_read_data2)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    assign rf_read_data1 = mem[rf_read_address1];
    assign rf_read_data2 = mem[rf_read_address2];

    always @(posedge clk) begin
        if (rf_valid_address[0]) begin
            mem[rf_write_address] = rf_write_data;
            wr_count = wr_count + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        if (ZERO_EN && a == 5'd0) return 16'h0000;
        return ref_rf[a];
    endfunction

    function automatic logic [15:0] model_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return 16'((32'(a) + 32'(b)) % 65536);
            2'b01:   return 16'((32'(a) + 65536 - 32'(b)) % 65536);
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic set_reg(input logic [4:0] a, input logic [15:0] v);
        mem[a]    = v;
        ref_rf[a] = v;
    endtask

    // Issue one command (called at a negedge while idle) and follow it
    // through the five cycles up to the next IDLE cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input bit hold);
        logic [15:0] a, b, expv;
        bit          wr_exp;
        int          wr0;
        a      = model_read(rs);
        b      = model_read(rt);
        expv   = model_alu(op, a, b);
        wr_exp = !(ZERO_EN && rd == 5'd0);
        wr0    = wr_count;
        start   = 1'b1;
        opcode  = op;
        rs_addr = rs;
        rt_addr = rt;
        rd_addr = rd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (hold) begin
                start   = 1'b1;
                opcode  = 2'($urandom_range(3));
                rs_addr = 5'($urandom_range(31));
                rt_addr = 5'($urandom_range(31));
                rd_addr = 5'($urandom_range(31));
            end else begin
                start = 1'b0;
            end
            check($sformatf("busy_c%0d", cyc), 32'(busy), 32'(cyc < 5));
            check($sformatf("done_c%0d", cyc), 32'(done), 32'(cyc == 4));
            case (cyc)
                1: begin
                    check("valid_read", 32'(rf_valid_address), 32'(3'b110));
                    check("rd_addr1", 32'(rf_read_address1), 32'(rs));
                    check("rd_addr2", 32'(rf_read_address2), 32'(rt));
                end
                3: begin
                    check("valid_write", 32'(rf_valid_address), 32'({2'b00, wr_exp}));
                    check("wr_addr", 32'(rf_write_address), 32'(rd));
                    check("wr_data", 32'(rf_write_data), 32'(expv));
                    check("result_wr", 32'(result), 32'(expv));
                end
                default: begin
                    check($sformatf("valid_c%0d", cyc), 32'(rf_valid_address), 32'(3'b000));
                end
            endcase
        end
        check("result", 32'(result), 32'(expv));
        check("wr_count", 32'(wr_count - wr0), 32'(wr_exp));
        if (wr_exp) ref_rf[rd] = expv;
        check("rd_value", 32'(mem[rd]), 32'(ref_rf[rd]));
        $display("[TB] op=%0d rs=%0d rt=%0d rd=%0d hold=%0d -> result=0x%04h", op, rs, rt, rd, hold, result);
    endtask

    initial begin
        int dn;
        int wr0;
        rst     = 1'b1;
        start   = 1'b0;
        opcode  = 2'b00;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        rd_addr = 5'd0;
        for (int i = 0; i < 32; i++) set_reg(5'(i), 16'($urandom_range(65535)));

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(rf_valid_address), 32'd0);
        check("rst_addrs", 32'({rf_read_address1, rf_read_address2, rf_write_address}), 32'd0);
        check("rst_wdata", 32'(rf_write_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic
        set_reg(5'd1, 16'd5);
        set_reg(5'd2, 16'd7);
        run_cmd(2'b00, 5'd1, 5'd2, 5'd3, 1'b0);
        check("add_5_7", 32'(result), 32'd12);
        check("r3_is_12", 32'(mem[3]), 32'd12);
        set_reg(5'd1, 16'h0000);
        set_reg(5'd2, 16'h0001);
        run_cmd(2'b01, 5'd1, 5'd2, 5'd6, 1'b0);
        check("sub_wrap", 32'(result), 32'h0000FFFF);
        set_reg(5'd1, 16'hFFFF);
        run_cmd(2'b00, 5'd1, 5'd2, 5'd6, 1'b0);
        check("add_wrap", 32'(result), 32'h00000000);
        set_reg(5'd1, 16'hF0F0);
        set_reg(5'd2, 16'h0FF0);
        run_cmd(2'b10, 5'd1, 5'd2, 5'd7, 1'b0);
        check("and_pat", 32'(result), 32'h000000F0);
        run_cmd(2'b11, 5'd1, 5'd2, 5'd8, 1'b0);
        check("or_pat", 32'(result), 32'h0000FFF0);

        // Back-to-back dependency through r4
        run_cmd(2'b00, 5'd1, 5'd2, 5'd4, 1'b0);
        run_cmd(2'b11, 5'd4, 5'd4, 5'd5, 1'b0);
        check("b2b_r5_eq_r4", 32'(mem[5]), 32'(ref_rf[4]));

        // start held high with junk inputs while busy
        for (int i = 0; i < 4; i++)
            run_cmd(2'($urandom_range(3)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                    5'($urandom_range(31)), 1'b1);
        start = 1'b0;

        // Asynchronous reset in the middle of WAIT
        wr0     = wr_count;
        start   = 1'b1;
        opcode  = 2'b00;
        rs_addr = 5'd1;
        rt_addr = 5'd2;
        rd_addr = 5'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #5 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_valid", 32'(rf_valid_address), 32'd0);
        check("arst_addrs", 32'({rf_read_address1, rf_read_address2, rf_write_address}), 32'd0);
        #4 rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dn += int'(done);
        end
        check("arst_no_done", 32'(dn), 32'd0);
        check("arst_no_write", 32'(wr_count - wr0), 32'd0);
        check("arst_r9_kept", 32'(mem[9]), 32'(ref_rf[9]));
        run_cmd(2'b01, 5'd1, 5'd2, 5'd9, 1'b0);

`ifdef RF_SEQ_ZERO_REG_EN
        // Register 0 behaviour
        mem[0] = 16'h1234;
        set_reg(5'd2, 16'd7);
        run_cmd(2'b00, 5'd1, 5'd2, 5'd0, 1'b0);
        check("zero_r0_unwritten", 32'(mem[0]), 32'h00001234);
        run_cmd(2'b00, 5'd0, 5'd2, 5'd10, 1'b0);
        check("zero_read_add", 32'(result), 32'd7);
`endif

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(3)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                    5'($urandom_range(31)), ($urandom_range(2) == 0));
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
